// File: rtl/pwm_pkg.sv
// Shared types for the dead-time PWM block: output-stage states and the
// width of the dead-time down-counter.
package pwm_pkg;

    localparam int DT_W = 8;

    typedef enum logic [2:0] {
        SAFE,
        LO,
        DT_LH,
        HI,
        DT_HL
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Output stage: turns the raw compare result into complementary high/low
// drives separated by a programmable dead-time. Outputs depend on state only,
// so both drives are low straight out of reset and on every disable.
module pwm_deadtime_fsm
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic raw_q,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
    localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

    pwm_state_t            state;
    pwm_state_t            state_nxt;
    logic      [DT_W-1:0]  dt_cnt;
    logic      [DT_W-1:0]  dt_nxt;

    // State and dead-time counter registers; reset lands in the safe state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SAFE;
            dt_cnt <= '0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_nxt;
        end
    end

    // Next-state logic; a low enable overrides every other transition.
    always_comb begin
        state_nxt = state;
        dt_nxt    = dt_cnt;
        case (state)
            SAFE: begin
                if (enable) begin
                    state_nxt = DT_HL;
                    dt_nxt    = DT_LOAD;
                end
            end
            LO: begin
                if (raw_q) begin
                    state_nxt = DT_LH;
                    dt_nxt    = DT_LOAD;
                end
            end
            DT_LH: begin
                // A pulse that ends inside the dead-time never reaches HI.
                if (!raw_q) begin
                    state_nxt = LO;
                end else if (dt_cnt == DT_ONE) begin
                    state_nxt = HI;
                end else begin
                    dt_nxt = dt_cnt - DT_ONE;
                end
            end
            HI: begin
                if (!raw_q) begin
                    state_nxt = DT_HL;
                    dt_nxt    = DT_LOAD;
                end
            end
            DT_HL: begin
                if (raw_q) begin
                    state_nxt = DT_LH;
                    dt_nxt    = DT_LOAD;
                end else if (dt_cnt == DT_ONE) begin
                    state_nxt = LO;
                end else begin
                    dt_nxt = dt_cnt - DT_ONE;
                end
            end
            default: begin
                state_nxt = SAFE;
                dt_nxt    = '0;
            end
        endcase
        if (!enable) begin
            state_nxt = SAFE;
            dt_nxt    = '0;
        end
    end

    assign pwm_hi = (state == HI);
    assign pwm_lo = (state == LO);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM generator driven by an external free-running counter.
// Duty updates are double-buffered: a handshake fills the shadow register and
// the value moves to the active register only at the counter wrap.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEADTIME = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt,
    input  logic         enable,
    input  logic         duty_valid,
    input  logic [W-1:0] duty_data,
    output logic         duty_ready,
    output logic         pending,
    output logic         pwm_hi,
    output logic         pwm_lo,
    output logic         period_strobe
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] shadow;
    logic [W-1:0] duty_active;
    logic [W-1:0] eff_duty;
    logic         period_start;
    logic         accept;
    logic         raw_q;

    // Previous counter value; all-ones at reset so the first zero is a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '1;
        else     cnt_q <= cnt;
    end

    // Edge-detect the wrap so a counter parked at zero yields one start only.
    assign period_start = (cnt == '0) && (cnt_q != '0);

    assign duty_ready = !pending;
    assign accept     = duty_valid && duty_ready;

    // Shadow fill on handshake, shadow-to-active transfer at period start.
    // Accept and apply are exclusive because ready is low while pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            duty_active <= '0;
            pending     <= 1'b0;
        end else if (accept) begin
            shadow  <= duty_data;
            pending <= 1'b1;
        end else if (period_start && pending) begin
            duty_active <= shadow;
            pending     <= 1'b0;
        end
    end

    // The new duty already governs the wrap cycle itself.
    assign eff_duty = (period_start && pending) ? shadow : duty_active;

    // Registered compare and period strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q         <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            raw_q         <= enable && (cnt < eff_duty);
            period_strobe <= period_start;
        end
    end

    pwm_deadtime_fsm #(
        .DEADTIME (DEADTIME)
    ) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .raw_q  (raw_q),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

endmodule
